// File: rtl/uart_dbg_pkg.sv
// Shared types and constants for the UART packet loader.
// Holds the CRC16/Modbus byte-step helper.
package uart_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_WRITE,
        ST_RESP,
        ST_DONE
    } state_t;

    localparam logic [7:0]  ACK_DEF  = 8'h06;
    localparam logic [7:0]  NACK_DEF = 8'h15;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    function automatic logic [15:0] crc16_byte(
        input logic [15:0] crc,
        input logic [7:0]  data
    );
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_modbus_byte.sv
// Combinational CRC16/Modbus update for one byte.
// The eight bit steps unroll inside the package helper.
module crc16_modbus_byte
    import uart_dbg_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    always_comb begin
        crc_o = crc16_byte(crc_i, data_i);
    end

endmodule

// File: rtl/uart_dbg_pkt_loader.sv
// Packet UART loader: SEQ + payload + CRC16 in, word writes out.
// Holds the core in reset until the whole image is in memory.
module uart_dbg_pkt_loader
    import uart_dbg_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES  = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned MAX_BYTES      = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ACK_BYTE       = ACK_DEF,
    parameter logic [7:0]  NACK_BYTE      = NACK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    output logic        halt_cpu,
    output logic        done,
    output logic [15:0] nack_cnt
);

    localparam int NW = PAYLOAD_BYTES / 4;
    localparam int AW = $clog2(PAYLOAD_BYTES);
    localparam int BW = $clog2(PAYLOAD_BYTES + 2);
    localparam int KW = $clog2(NW + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    exp_q, exp_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [15:0]   crc_q, crc_d;
    logic [15:0]   crc_rx_q, crc_rx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   size_q, size_d;
    logic [31:0]   off_q, off_d;
    logic          have_q, have_d;
    logic [KW-1:0] k_q, k_d;
    logic          ack_q, ack_d;
    logic          adv_q, adv_d;
    logic          fin_q, fin_d;
    logic          done_q, done_d;
    logic          en_q;
    logic [15:0]   nack_q, nack_d;
    logic [7:0]    tx_q, tx_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdat_q, wdat_d;

    logic [7:0]    pay_q [PAYLOAD_BYTES];
    logic          pay_we;
    logic [15:0]   crc_nx;
    logic [31:0]   pkt_size;
    logic [31:0]   size_r4;
    logic [31:0]   nxt_off;
    logic          last_word;

    crc16_modbus_byte u_crc (
        .crc_i  (crc_q),
        .data_i (rx_data),
        .crc_o  (crc_nx)
    );

    function automatic logic [31:0] word_at(input logic [KW-1:0] k);
        logic [AW-1:0] b;
        b = AW'({k, 2'b00});
        return {pay_q[b + AW'(3)], pay_q[b + AW'(2)],
                pay_q[b + AW'(1)], pay_q[b]};
    endfunction

    assign pkt_size = {pay_q[AW'(PAYLOAD_BYTES - 4)],
                       pay_q[AW'(PAYLOAD_BYTES - 3)],
                       pay_q[AW'(PAYLOAD_BYTES - 2)],
                       pay_q[AW'(PAYLOAD_BYTES - 1)]};
    assign size_r4   = (size_q + 32'd3) & ~32'd3;
    assign nxt_off   = off_q + 32'({k_q, 2'b00}) + 32'd4;
    // pad words past the rounded-up image size are never written
    assign last_word = (k_q == KW'(NW - 1)) || (nxt_off >= size_r4);

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        exp_d    = exp_q;
        bcnt_d   = bcnt_q;
        crc_d    = crc_q;
        crc_rx_d = crc_rx_q;
        tmo_d    = tmo_q;
        size_d   = size_q;
        off_d    = off_q;
        have_d   = have_q;
        k_d      = k_q;
        ack_d    = ack_q;
        adv_d    = adv_q;
        fin_d    = fin_q;
        done_d   = done_q;
        nack_d   = nack_q;
        tx_d     = tx_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        pay_we   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en && rx_valid) begin
                    seq_d   = rx_data;
                    bcnt_d  = '0;
                    crc_d   = CRC_INIT;
                    tmo_d   = '0;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    if (bcnt_q < BW'(PAYLOAD_BYTES)) begin
                        pay_we = 1'b1;
                        crc_d  = crc_nx;
                        bcnt_d = bcnt_q + BW'(1);
                    end else if (bcnt_q == BW'(PAYLOAD_BYTES)) begin
                        crc_rx_d[7:0] = rx_data;
                        bcnt_d        = bcnt_q + BW'(1);
                    end else begin
                        crc_rx_d[15:8] = rx_data;
                        state_d        = ST_CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    ack_d   = 1'b0;
                    adv_d   = 1'b0;
                    fin_d   = 1'b0;
                    tx_d    = NACK_BYTE;
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHECK: begin
                ack_d   = 1'b0;
                adv_d   = 1'b0;
                fin_d   = 1'b0;
                tx_d    = NACK_BYTE;
                state_d = ST_RESP;
                if (crc_rx_q != crc_q) begin
                    ack_d = 1'b0;
                end else if (exp_q != 8'd0 && seq_q == exp_q - 8'd1) begin
                    // host lost our ACK: confirm again, write nothing
                    ack_d = 1'b1;
                    tx_d  = ACK_BYTE;
                end else if (seq_q != exp_q) begin
                    ack_d = 1'b0;
                end else if (!have_q) begin
                    if (pkt_size <= MAX_BYTES) begin
                        ack_d  = 1'b1;
                        adv_d  = 1'b1;
                        fin_d  = (pkt_size == 32'd0);
                        size_d = pkt_size;
                        tx_d   = ACK_BYTE;
                    end
                end else begin
                    ack_d   = 1'b1;
                    adv_d   = 1'b1;
                    fin_d   = (off_q + 32'(PAYLOAD_BYTES) >= size_q);
                    tx_d    = ACK_BYTE;
                    k_d     = '0;
                    addr_d  = BASE_ADDR + off_q;
                    wdat_d  = word_at('0);
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_gnt) begin
                    if (last_word) begin
                        state_d = ST_RESP;
                    end else begin
                        k_d    = k_q + KW'(1);
                        addr_d = addr_q + 32'd4;
                        wdat_d = word_at(k_q + KW'(1));
                    end
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                    if (!ack_q && nack_q != 16'hFFFF) begin
                        nack_d = nack_q + 16'd1;
                    end
                    if (ack_q && adv_q) begin
                        exp_d = exp_q + 8'd1;
                        if (have_q) begin
                            off_d = off_q + 32'(PAYLOAD_BYTES);
                        end else begin
                            have_d = 1'b1;
                        end
                        if (fin_q) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (en && !en_q) begin
            done_d = 1'b0;
        end
        // a dropped strap abandons the download but keeps done/nack_cnt
        if (!en) begin
            state_d = ST_IDLE;
            exp_d   = '0;
            size_d  = '0;
            off_d   = '0;
            have_d  = 1'b0;
            done_d  = done_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            seq_q    <= '0;
            exp_q    <= '0;
            bcnt_q   <= '0;
            crc_q    <= CRC_INIT;
            crc_rx_q <= '0;
            tmo_q    <= '0;
            size_q   <= '0;
            off_q    <= '0;
            have_q   <= 1'b0;
            k_q      <= '0;
            ack_q    <= 1'b0;
            adv_q    <= 1'b0;
            fin_q    <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            nack_q   <= '0;
            tx_q     <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            exp_q    <= exp_d;
            bcnt_q   <= bcnt_d;
            crc_q    <= crc_d;
            crc_rx_q <= crc_rx_d;
            tmo_q    <= tmo_d;
            size_q   <= size_d;
            off_q    <= off_d;
            have_q   <= have_d;
            k_q      <= k_d;
            ack_q    <= ack_d;
            adv_q    <= adv_d;
            fin_q    <= fin_d;
            done_q   <= done_d;
            en_q     <= en;
            nack_q   <= nack_d;
            tx_q     <= tx_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pay_we) begin
            pay_q[bcnt_q[AW-1:0]] <= rx_data;
        end
    end

    assign tx_data   = tx_q;
    assign tx_valid  = (state_q == ST_RESP);
    assign mem_req   = (state_q == ST_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdat_q;
    assign done      = done_q;
    assign halt_cpu  = en & ~done_q;
    assign nack_cnt  = nack_q;

endmodule
